layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_layer_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer -- drives an external MAC unit through one fully-connected
// layer. For each neuron it clears the accumulator and streams NUM_INPUTS
// activation/weight products into it. It then flushes the MAC pipeline with
// DRAIN_CYCLES zero-operand enables, and presents the clamped/ReLU'd result
// on a valid/ready port.
//
// Optional feature: define LAYER_SEQUENCER_BIAS_EN to add a bias_data input.
// The bias is accumulated as bias_data*1 in one extra cycle between CLEAR and
// FEED, which makes each neuron one cycle longer.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             layer start request, sampled only in IDLE
//   busy, done        busy = not IDLE; done = one-cycle pulse after last result
//   act_addr/wgt_addr read addresses for the activation and weight memories
//   act_data/wgt_data read data, valid the cycle after the address
//   mac_a/mac_b       MAC operands (zero when mac_enable is low)
//   mac_enable        MAC accumulate strobe
//   mac_clear         MAC accumulator clear pulse
//   mac_out           clamped, ReLU'd MAC result
//   result_*          result_valid/result_ready handshake, with result_data
//                     and result_index (the neuron number)
//   bias_data         (LAYER_SEQUENCER_BIAS_EN only) bias of the current neuron
module layer_sequencer #(
  parameter int WIDTH        = 8,
  parameter int NUM_INPUTS   = 3,
  parameter int NUM_OUTPUTS  = 4,
  parameter int DRAIN_CYCLES = 2,
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int WW = (NUM_INPUTS*NUM_OUTPUTS > 1) ? $clog2(NUM_INPUTS*NUM_OUTPUTS) : 1,
  localparam int IW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           act_addr,
  output logic [WW-1:0]           wgt_addr,
  input  logic signed [WIDTH-1:0] act_data,
  input  logic signed [WIDTH-1:0] wgt_data,
`ifdef LAYER_SEQUENCER_BIAS_EN
  input  logic signed [WIDTH-1:0] bias_data,
`endif
  output logic signed [WIDTH-1:0] mac_a,
  output logic signed [WIDTH-1:0] mac_b,
  output logic                    mac_enable,
  output logic                    mac_clear,
  input  logic signed [WIDTH-1:0] mac_out,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic signed [WIDTH-1:0] result_data,
  output logic [IW-1:0]           result_index
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
`ifdef LAYER_SEQUENCER_BIAS_EN
    BIAS,
`endif
    FEED,
    DRAIN,
    EMIT
  } state_t;

  state_t          state, state_d;
  logic [7:0]      cnt;        // FEED cycle index 0..NUM_INPUTS
  logic [2:0]      drain_cnt;
  logic [IW-1:0]   neuron;
  logic [WW-1:0]   wgt_base;   // neuron*NUM_INPUTS, kept incrementally

  logic last_feed, last_addr, last_drain, last_neuron, handshake;

  // FEED cycle 0 only issues address 0. Cycles 1..NUM_INPUTS consume the data
  // returned for the previous address, so FEED lasts NUM_INPUTS+1 cycles.
  assign last_feed   = (cnt == 8'(NUM_INPUTS));
  assign last_addr   = (cnt >= 8'(NUM_INPUTS - 1));
  assign last_drain  = (drain_cnt == 3'(DRAIN_CYCLES - 1));
  assign last_neuron = (neuron == IW'(NUM_OUTPUTS - 1));
  assign handshake   = result_valid & result_ready;
  assign busy        = (state != IDLE);

  // Next state and MAC strobes. The operands are forced to zero whenever no
  // enable is issued.
  always_comb begin
    state_d    = state;
    mac_enable = 1'b0;
    mac_clear  = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    case (state)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: begin
        mac_clear = 1'b1;
`ifdef LAYER_SEQUENCER_BIAS_EN
        state_d   = BIAS;
`else
        state_d   = FEED;
`endif
      end
`ifdef LAYER_SEQUENCER_BIAS_EN
      BIAS: begin
        mac_enable = 1'b1;
        mac_a      = bias_data;
        mac_b      = WIDTH'(1);
        state_d    = FEED;
      end
`endif
      FEED: begin
        if (cnt != 8'd0) begin
          mac_enable = 1'b1;
          mac_a      = act_data;
          mac_b      = wgt_data;
        end
        if (last_feed) state_d = DRAIN;
      end
      DRAIN: begin
        mac_enable = 1'b1;
        if (last_drain) state_d = EMIT;
      end
      EMIT: if (handshake) state_d = last_neuron ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Counters, address generation and the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      drain_cnt    <= '0;
      neuron       <= '0;
      wgt_base     <= '0;
      act_addr     <= '0;
      wgt_addr     <= '0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_index <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neuron   <= '0;
          wgt_base <= '0;
        end
        CLEAR: begin
          // Address 0 of this neuron is issued from here. It stays on the bus
          // through the bias cycle, when that cycle is present.
          cnt       <= '0;
          drain_cnt <= '0;
          act_addr  <= '0;
          wgt_addr  <= wgt_base;
        end
        FEED: if (!last_feed) begin
          cnt <= cnt + 8'd1;
          if (!last_addr) begin
            act_addr <= act_addr + 1'b1;
            wgt_addr <= wgt_addr + 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (last_drain) begin
            result_valid <= 1'b1;
            result_data  <= mac_out;
            result_index <= neuron;
          end
        end
        EMIT: if (handshake) begin
          result_valid <= 1'b0;
          if (last_neuron) begin
            done <= 1'b1;
          end else begin
            neuron   <= neuron + 1'b1;
            wgt_base <= wgt_base + WW'(NUM_INPUTS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

`ifdef LAYER_SEQUENCER_BIAS_EN
  localparam int BV  = 10;
  localparam int BEN = 1;
`else
  localparam int BV  = 0;
  localparam int BEN = 0;
`endif
  // 1 (CLEAR) + 1 (address cycle) + 3 products + 2 drain, plus the bias cycle
  localparam int LAT = 7 + BEN;
  localparam int ENS = 3 + 2 + BEN;

  logic              clk = 1'b0;
  logic              reset, start, busy, done;
  logic [1:0]        act_addr;
  logic [3:0]        wgt_addr;
  logic signed [7:0] act_data, wgt_data, mac_a, mac_b, mac_out;
  logic              mac_enable, mac_clear;
  logic              result_valid, result_ready;
  logic signed [7:0] result_data;
  logic [1:0]        result_index;
`ifdef LAYER_SEQUENCER_BIAS_EN
  logic signed [7:0] bias_data = 8'sd10;
`endif

  logic signed [7:0] act_mem [0:2];
  logic signed [7:0] wgt_mem [0:15];
  int acc;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .wgt_addr(wgt_addr),
    .act_data(act_data), .wgt_data(wgt_data),
`ifdef LAYER_SEQUENCER_BIAS_EN
    .bias_data(bias_data),
`endif
    .mac_a(mac_a), .mac_b(mac_b), .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_out(mac_out), .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_index(result_index)
  );

  // Registered-read memories and a simple accumulate/ReLU/clamp MAC.
  always @(posedge clk) begin
    act_data <= act_mem[act_addr];
    wgt_data <= wgt_mem[wgt_addr];
    if (mac_clear) acc <= 0;
    else if (mac_enable) acc <= acc + int'(mac_a) * int'(mac_b);
  end
  always_comb mac_out = (acc < 0) ? 8'sd0 : (acc > 127) ? 8'sd127 : 8'(acc);

  function automatic int rl(input int v);
    return (v < 0) ? 0 : (v > 127) ? 127 : v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Follows one neuron from CLEAR to its handshake. stall>0 holds
  // result_ready low for that many cycles once result_valid is up.
  task automatic run_neuron(input int idx, input int expv, input int stall, input bit last);
    int n, lat, en;
    bit ok;
    result_ready = (stall == 0);
    n = 0;
    while (!mac_clear && n < 20) begin cycle(); n++; end
    chk("clear_seen", 32'(mac_clear), 1);
    lat = 0; en = 0;
    while (!result_valid && lat < 40) begin
      en += int'(mac_enable);
      cycle();
      lat++;
      if (lat == 1) begin
        chk("act_addr_first", 32'(act_addr), 0);
        chk("wgt_addr_first", 32'(wgt_addr), 32'(idx * 3));
      end
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("enable_count", 32'(en), 32'(ENS));
    chk("result_data", 32'(result_data), 32'(expv));
    chk("result_index", 32'(result_index), 32'(idx));
    if (stall > 0) begin
      ok = 1'b1;
      for (int k = 0; k < stall; k++) begin
        cycle();
        ok &= result_valid && (result_data == 8'(expv)) && (result_index == 2'(idx)) && !mac_enable;
      end
      chk("stall_hold", 32'(ok), 1);
      result_ready = 1'b1;
    end
    cycle();
    chk("valid_drop", 32'(result_valid), 0);
    if (!last) chk("next_clear", 32'(mac_clear), 1);
    else begin
      chk("done_pulse", 32'(done), 1);
      chk("busy_fall", 32'(busy), 0);
    end
  endtask

  initial begin
    bit ok;
    act_mem = '{8'sd1, 8'sd2, 8'sd3};
    wgt_mem = '{8'sd4, 8'sd5, 8'sd6, -8'sd2, -8'sd2, -8'sd2, 8'sd10, 8'sd10, 8'sd10,
                8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    acc = 0;
    reset = 1'b1; start = 1'b0; result_ready = 1'b1;
    #1;
    chk("rst_ctrl", 32'({busy, done, mac_enable, mac_clear, result_valid}), 0);
    chk("rst_ops", 32'({mac_a, mac_b}), 0);
    chk("rst_result", 32'({result_data, result_index}), 0);
    chk("rst_addr", 32'({act_addr, wgt_addr}), 0);
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("idle_busy", 32'(busy), 0);

    // Layer 1: start is held high throughout and must not disturb the layer.
    // Raw dot products are 32, -12, 60 and 3.
    start = 1'b1;
    run_neuron(0, rl(32 + BV), 0, 0);
    run_neuron(1, rl(-12 + BV), 0, 0);
    run_neuron(2, rl(60 + BV), 5, 0);
    run_neuron(3, rl(3 + BV), 0, 1);
    // Start, still high in the done cycle, is taken from IDLE on the next edge.
    act_mem = '{8'sd1, 8'sd1, 8'sd1};
    cycle();
    chk("restart_clear", 32'(mac_clear), 1);
    chk("done_once", 32'(done), 0);
    start = 1'b0;

    // Layer 2 with act=[1,1,1]: raw 15, -6, 30, 1
    run_neuron(0, rl(15 + BV), 0, 0);
    run_neuron(1, rl(-6 + BV), 0, 0);
    run_neuron(2, rl(30 + BV), 0, 0);
    run_neuron(3, rl(1 + BV), 0, 1);
    cycle();
    chk("done_single", 32'(done), 0);
    chk("idle_after", 32'(busy), 0);

    // Layer 3: reset during FEED of neuron 2
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_neuron(0, rl(15 + BV), 0, 0);
    run_neuron(1, rl(-6 + BV), 0, 0);
    cycle(); cycle();
    chk("pre_reset_busy", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_ctrl", 32'({busy, done, mac_enable, mac_clear, result_valid}), 0);
    chk("async_ops", 32'({mac_a, mac_b}), 0);
    chk("async_result", 32'({result_data, result_index}), 0);
    chk("async_addr", 32'({act_addr, wgt_addr}), 0);
    cycle();
    reset = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      ok &= !done && !busy && !result_valid;
    end
    chk("no_done_after_reset", 32'(ok), 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_neuron(0, rl(15 + BV), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the run overruns.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
